rtype_exec_unit: RTL and testbench
==================================

# rtype_exec_unit

Multi-cycle R-type execution sequencer for the MIPS datapath, sitting directly around the 32×32 register file. It accepts one 32-bit R-type instruction per handshake, drives the register file's two read addresses, captures both operands, computes the ALU result, and drives the register file's write port for exactly one cycle. It is the single reader and writer of the register file for R-type instructions. It enforces $0 as read-only, because the register file itself does not.

## Interface
Parameters: none (widths fixed: 32-bit data, 5-bit register addresses).

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock domain
- inst_valid  in  1  instruction offered
- inst_ready  out  1  unit can accept; high only in IDLE
- inst  in  32  instruction word: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]
- R_Addr_A  out  5  register-file read port A address (rs)
- R_Addr_B  out  5  register-file read port B address (rt)
- R_Data_A  in  32  register-file read data A (combinational from R_Addr_A)
- R_Data_B  in  32  register-file read data B
- W_Addr  out  5  write address (rd)
- W_Data  out  32  write data (result)
- Write_Reg  out  1  write enable to the register file
- done  out  1  one-cycle pulse in the WB cycle
- illegal  out  1  one-cycle pulse with done when the instruction is unsupported
- ZF  out  1  result == 0, held until the next accept
- OF  out  1  signed overflow of add/sub, held until the next accept

## Operation
- FSM states: IDLE → RD → EX → WB → IDLE.
- IDLE: inst_ready=1. On inst_valid && inst_ready, latch inst into the instruction register and go to RD. Otherwise stay in IDLE.
- RD: R_Addr_A=rs and R_Addr_B=rt, both taken from the latched instruction (stable in all non-IDLE states). At the clock edge, latch R_Data_A/R_Data_B into opA/opB. Go to EX.
- EX: compute from opA, opB and shamt. At the clock edge, latch result, ZF, OF and the illegal decision. Go to WB.
- WB: W_Addr=rd, W_Data=result, Write_Reg=1 unless the write is suppressed. done=1. illegal=1 if the instruction is unsupported. Go to IDLE.
- Write is suppressed if any of the following holds:
  - rd==0
  - op≠0 or funct is unsupported (illegal)
  - add/sub with signed overflow
- Supported funct values:
  - 0x20 add: signed; OF = (a[31]==b[31]) && (r[31]≠a[31])
  - 0x21 addu
  - 0x22 sub: signed; OF = (a[31]≠b[31]) && (r[31]≠a[31])
  - 0x23 subu
  - 0x24 and
  - 0x25 or
  - 0x26 xor
  - 0x27 nor
  - 0x2A slt: signed compare, result 0 or 1
  - 0x2B sltu: unsigned compare, result 0 or 1
  - 0x00 sll: rt << shamt
  - 0x02 srl: logical right shift
  - 0x03 sra: arithmetic right shift
- Arithmetic is mod 2^32. OF is 0 for all ops other than add/sub. On illegal instructions: result=0, ZF=1, OF=0.
- W_Addr and W_Data are driven in all states. Only Write_Reg qualifies them.

## Timing
- Accept at edge T. Operands are latched at T+1, the result at T+2, and the register-file write commits at T+3. The unit is back in IDLE after T+3.
- inst_ready is high again in the cycle after WB, so the next accept is at T+4. Throughput is one instruction per 4 cycles.
- Back-to-back dependency (rd of instruction N = rs of N+1): N+1 reads the updated value, since the write commits before N+1's RD cycle. No forwarding is needed.
- Reset values (cycle after reset sampled high): state=IDLE, inst_ready=1, instruction register=0, so R_Addr_A/B=0 and W_Addr=0. W_Data=0, Write_Reg=0, done=0, illegal=0, ZF=0, OF=0.
- Reset mid-operation (in RD/EX/WB): abort with no write. If reset is high in the WB cycle, Write_Reg is forced to 0 combinationally.
- inst_valid while not in IDLE is ignored. inst is sampled only on accept.
- Write_Reg, done and illegal are each exactly one cycle wide and never asserted outside WB.

## Test plan
- Reg file preset $1=0x7FFFFFFF, $2=1; inst add $3,$1,$2 (0x00221820) → no write to $3, OF=1, done pulse, illegal=0; then addu $3,$1,$2 → $3=0x80000000, OF=0.
- $4=0xFFFFFFF0, $5=3: slt $6,$4,$5 → $6=1; sltu $6,$4,$5 → $6=0; sra $7,$4,2 → $7=0xFFFFFFFC; srl $7,$4,2 → $7=0x3FFFFFFC.
- Any op with rd=0 (e.g. or $0,$1,$2) → Write_Reg stays 0 through WB, done=1, $0 still 0.
- op=0x08 or funct=0x18 → illegal=1 with done, no Write_Reg, ZF=1.
- Back-to-back: sub $8,$2,$2, then nor $9,$8,$8 with inst_valid held high → $8=0, ZF=1, then $9=0xFFFFFFFF. Accepts are 4 cycles apart, with inst_ready low for 3 of them.
- Reset asserted during the EX cycle of xor $10,$1,$2 → $10 unchanged, no done, inst_ready=1 on the cycle after reset, and all outputs at their reset values.

Source files
------------

// File: rtl/rtype_exec_if.sv
// Instruction handshake plus register-file port bundle for the R-type sequencer.
// The master side drives instructions and returns read data; the slave side is the sequencer.
interface rtype_exec_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [4:0]  R_Addr_A;
  logic [4:0]  R_Addr_B;
  logic [31:0] R_Data_A;
  logic [31:0] R_Data_B;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;
  logic        Write_Reg;
  logic        done;
  logic        illegal;
  logic        ZF;
  logic        OF;

  modport master (
    output inst_valid, inst, R_Data_A, R_Data_B,
    input  inst_ready, R_Addr_A, R_Addr_B, W_Addr, W_Data, Write_Reg, done, illegal, ZF, OF
  );

  modport slave (
    input  inst_valid, inst, R_Data_A, R_Data_B,
    output inst_ready, R_Addr_A, R_Addr_B, W_Addr, W_Data, Write_Reg, done, illegal, ZF, OF
  );
endinterface

// File: rtl/rtype_exec_unit.sv
// R-type sequencer: IDLE -> RD -> EX -> WB, one instruction per 4 cycles, write commits 3 edges after accept.
// inst_ready is high only in IDLE; offers while busy are ignored. $0 is never written.
module rtype_exec_unit (
  input  logic         clk,
  input  logic         reset,
  rtype_exec_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RD, EX, WB} state_t;

  state_t      state, state_nxt;
  logic [31:0] ir, op_a, op_b, result, res_nxt;
  logic        zf_q, of_q, ill_q, sup_q;
  logic        of_nxt, ill_nxt;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] sum, diff;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign shamt = ir[10:6];
  assign funct = ir[5:0];
  assign sum   = op_a + op_b;
  assign diff  = op_a - op_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ir     <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      zf_q   <= 1'b0;
      of_q   <= 1'b0;
      ill_q  <= 1'b0;
      sup_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.inst_valid) ir <= bus.inst;
      if (state == RD) begin
        op_a <= bus.R_Data_A;
        op_b <= bus.R_Data_B;
      end
      if (state == EX) begin
        result <= res_nxt;
        zf_q   <= (res_nxt == 32'd0);
        of_q   <= of_nxt;
        ill_q  <= ill_nxt;
        sup_q  <= ill_nxt | of_nxt | (rd == 5'd0);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.inst_valid) state_nxt = RD;
      RD:      state_nxt = EX;
      EX:      state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Illegal instructions fall through with result 0 so ZF reads 1.
  always_comb begin
    res_nxt = 32'd0;
    of_nxt  = 1'b0;
    ill_nxt = 1'b0;
    if (op != 6'd0) begin
      ill_nxt = 1'b1;
    end else begin
      case (funct)
        6'h20: begin
          res_nxt = sum;
          of_nxt  = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
        end
        6'h21: res_nxt = sum;
        6'h22: begin
          res_nxt = diff;
          of_nxt  = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
        end
        6'h23: res_nxt = diff;
        6'h24: res_nxt = op_a & op_b;
        6'h25: res_nxt = op_a | op_b;
        6'h26: res_nxt = op_a ^ op_b;
        6'h27: res_nxt = ~(op_a | op_b);
        6'h2A: res_nxt = {31'd0, $signed(op_a) < $signed(op_b)};
        6'h2B: res_nxt = {31'd0, op_a < op_b};
        6'h00: res_nxt = op_b << shamt;
        6'h02: res_nxt = op_b >> shamt;
        6'h03: res_nxt = $signed(op_b) >>> shamt;
        default: ill_nxt = 1'b1;
      endcase
    end
  end

  assign bus.inst_ready = (state == IDLE);
  assign bus.R_Addr_A   = rs;
  assign bus.R_Addr_B   = rt;
  assign bus.W_Addr     = rd;
  assign bus.W_Data     = result;
  // Reset during WB must kill the write in that same cycle.
  assign bus.Write_Reg  = (state == WB) && !sup_q && !reset;
  assign bus.done       = (state == WB) && !reset;
  assign bus.illegal    = (state == WB) && ill_q && !reset;
  assign bus.ZF         = zf_q;
  assign bus.OF         = of_q;
endmodule

// File: tb/tb_rtype_exec_unit.sv
// Directed bench: behavioural register file around rtype_exec_unit, hand-computed expectations.
module tb_rtype_exec_unit;
  logic clk = 1'b0;
  logic reset;
  rtype_exec_if bus ();

  rtype_exec_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  logic        pre_we;
  logic [4:0]  pre_a;
  logic [31:0] pre_d;

  assign bus.R_Data_A = rf[bus.R_Addr_A];
  assign bus.R_Data_B = rf[bus.R_Addr_B];

  always @(posedge clk) begin
    if (pre_we) rf[pre_a] <= pre_d;
    else if (bus.Write_Reg) rf[bus.W_Addr] <= bus.W_Data;
  end

  int vectors = 0;
  int miscompares = 0;

  logic        seen, wr, ill, stray;
  logic [4:0]  wa;
  logic [31:0] wd;
  int          lat;

  function automatic logic [31:0] rinst(input logic [4:0] rs_, input logic [4:0] rt_,
                                        input logic [4:0] rd_, input logic [4:0] sh, input logic [5:0] fn);
    return {6'd0, rs_, rt_, rd_, sh, fn};
  endfunction

  task automatic preset(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk); pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk); pre_we = 1'b0;
  endtask

  // Issues one instruction from IDLE and returns what was seen in WB; leaves the bench in IDLE after commit.
  task automatic exec(input logic [31:0] i);
    seen = 0; wr = 0; ill = 0; wa = 0; wd = 0; lat = 0; stray = 0;
    @(negedge clk); bus.inst = i; bus.inst_valid = 1'b1;
    @(negedge clk); bus.inst_valid = 1'b0; bus.inst = 32'hDEADBEEF;
    for (int c = 1; c <= 8 && !seen; c++) begin
      if (bus.done) begin
        seen = 1; wr = bus.Write_Reg; ill = bus.illegal; wa = bus.W_Addr; wd = bus.W_Data; lat = c;
      end else begin
        if (bus.Write_Reg || bus.illegal) stray = 1;
        @(negedge clk);
      end
    end
    if (seen) begin
      @(negedge clk);
      if (bus.done || bus.Write_Reg || bus.illegal || !bus.inst_ready) stray = 1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.inst_valid = 1'b0; bus.inst = '0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    for (int k = 0; k < 32; k++) rf[k] = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (bus.inst_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", bus.inst_ready); end
    vectors++; if ({bus.R_Addr_A, bus.R_Addr_B, bus.W_Addr} !== 15'd0) begin miscompares++; $display("FAIL reset_addrs got %h/%h/%h want 0", bus.R_Addr_A, bus.R_Addr_B, bus.W_Addr); end
    vectors++; if (bus.W_Data !== 32'd0) begin miscompares++; $display("FAIL reset_wdata got %h want 0", bus.W_Data); end
    vectors++; if ({bus.Write_Reg, bus.done, bus.illegal, bus.ZF, bus.OF} !== 5'd0) begin miscompares++; $display("FAIL reset_flags got %b want 00000", {bus.Write_Reg, bus.done, bus.illegal, bus.ZF, bus.OF}); end
  endtask

  task automatic test_overflow;
    preset(1, 32'h7FFFFFFF); preset(2, 32'h1); preset(3, 32'h1234);
    exec(32'h00221820);
    vectors++; if (seen !== 1'b1 || lat != 3) begin miscompares++; $display("FAIL add_done seen=%b lat=%0d want 1/3", seen, lat); end
    vectors++; if (wr !== 1'b0 || ill !== 1'b0) begin miscompares++; $display("FAIL add_wr_ill got %b%b want 00", wr, ill); end
    vectors++; if (bus.OF !== 1'b1 || bus.ZF !== 1'b0) begin miscompares++; $display("FAIL add_flags OF=%b ZF=%b want 1/0", bus.OF, bus.ZF); end
    vectors++; if (rf[3] !== 32'h1234) begin miscompares++; $display("FAIL add_nowrite got %h want 00001234", rf[3]); end
    exec(rinst(1, 2, 3, 0, 6'h21));
    vectors++; if (wr !== 1'b1 || wa !== 5'd3 || wd !== 32'h80000000) begin miscompares++; $display("FAIL addu_wb wr=%b wa=%0d wd=%h want 1/3/80000000", wr, wa, wd); end
    vectors++; if (rf[3] !== 32'h80000000 || bus.OF !== 1'b0) begin miscompares++; $display("FAIL addu_result got %h OF=%b want 80000000/0", rf[3], bus.OF); end
    vectors++; if (stray !== 1'b0) begin miscompares++; $display("FAIL addu_pulse stray=%b want 0", stray); end
  endtask

  task automatic test_compare_shift;
    preset(4, 32'hFFFFFFF0); preset(5, 32'h3);
    exec(rinst(4, 5, 6, 0, 6'h2A));
    vectors++; if (rf[6] !== 32'd1) begin miscompares++; $display("FAIL slt got %h want 00000001", rf[6]); end
    exec(rinst(4, 5, 6, 0, 6'h2B));
    vectors++; if (rf[6] !== 32'd0 || bus.ZF !== 1'b1) begin miscompares++; $display("FAIL sltu got %h ZF=%b want 0/1", rf[6], bus.ZF); end
    exec(rinst(0, 4, 7, 2, 6'h03));
    vectors++; if (rf[7] !== 32'hFFFFFFFC) begin miscompares++; $display("FAIL sra got %h want fffffffc", rf[7]); end
    exec(rinst(0, 4, 7, 2, 6'h02));
    vectors++; if (rf[7] !== 32'h3FFFFFFC) begin miscompares++; $display("FAIL srl got %h want 3ffffffc", rf[7]); end
    exec(rinst(0, 5, 7, 4, 6'h00));
    vectors++; if (rf[7] !== 32'h30) begin miscompares++; $display("FAIL sll got %h want 00000030", rf[7]); end
  endtask

  task automatic test_logic_arith;
    exec(rinst(1, 4, 13, 0, 6'h24));
    vectors++; if (rf[13] !== 32'h7FFFFFF0) begin miscompares++; $display("FAIL and got %h want 7ffffff0", rf[13]); end
    exec(rinst(5, 4, 14, 0, 6'h23));
    vectors++; if (rf[14] !== 32'h13) begin miscompares++; $display("FAIL subu got %h want 00000013", rf[14]); end
    preset(15, 32'h99);
    exec(rinst(1, 4, 15, 0, 6'h22));
    vectors++; if (rf[15] !== 32'h99 || wr !== 1'b0 || bus.OF !== 1'b1) begin miscompares++; $display("FAIL sub_ovf got %h wr=%b OF=%b want 00000099/0/1", rf[15], wr, bus.OF); end
  endtask

  task automatic test_rd_zero;
    exec(rinst(1, 2, 0, 0, 6'h25));
    vectors++; if (seen !== 1'b1 || wr !== 1'b0 || stray !== 1'b0) begin miscompares++; $display("FAIL rd0_wr seen=%b wr=%b stray=%b want 1/0/0", seen, wr, stray); end
    vectors++; if (rf[0] !== 32'd0) begin miscompares++; $display("FAIL rd0_reg got %h want 0", rf[0]); end
  endtask

  task automatic test_illegal;
    preset(11, 32'h5A5A);
    exec(rinst(1, 2, 11, 0, 6'h20) | 32'h20000000);
    vectors++; if (seen !== 1'b1 || ill !== 1'b1 || wr !== 1'b0) begin miscompares++; $display("FAIL op08 seen=%b ill=%b wr=%b want 1/1/0", seen, ill, wr); end
    vectors++; if (bus.ZF !== 1'b1 || bus.OF !== 1'b0 || rf[11] !== 32'h5A5A) begin miscompares++; $display("FAIL op08_state ZF=%b OF=%b r11=%h want 1/0/5a5a", bus.ZF, bus.OF, rf[11]); end
    exec(rinst(1, 2, 0, 0, 6'h25));
    exec(rinst(1, 2, 11, 0, 6'h18));
    vectors++; if (ill !== 1'b1 || wr !== 1'b0 || bus.ZF !== 1'b1 || rf[11] !== 32'h5A5A) begin miscompares++; $display("FAIL fn18 ill=%b wr=%b ZF=%b r11=%h want 1/0/1/5a5a", ill, wr, bus.ZF, rf[11]); end
  endtask

  task automatic test_back_to_back;
    int n, c0, c1, lows;
    logic zf8;
    preset(8, 32'h55);
    n = 0; c0 = 0; c1 = 0; lows = 0; zf8 = 1'b0;
    @(negedge clk); bus.inst = rinst(2, 2, 8, 0, 6'h22); bus.inst_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (bus.done && n == 1) zf8 = bus.ZF;
      if (bus.inst_valid && bus.inst_ready) begin
        if (n == 0) c0 = c; else c1 = c;
        n++;
      end else if (n == 1 && !bus.inst_ready) lows++;
      @(negedge clk);
      if (n == 1) bus.inst = rinst(8, 8, 9, 0, 6'h27);
      if (n == 2) bus.inst_valid = 1'b0;
    end
    vectors++; if (n != 2 || c1 - c0 != 4 || lows != 3) begin miscompares++; $display("FAIL b2b_spacing n=%0d gap=%0d lows=%0d want 2/4/3", n, c1 - c0, lows); end
    vectors++; if (rf[8] !== 32'd0 || zf8 !== 1'b1) begin miscompares++; $display("FAIL b2b_sub got %h ZF=%b want 0/1", rf[8], zf8); end
    vectors++; if (rf[9] !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL b2b_nor got %h want ffffffff", rf[9]); end
  endtask

  task automatic test_reset_mid;
    logic any_done;
    preset(10, 32'hABCD);
    @(negedge clk); bus.inst = rinst(1, 2, 10, 0, 6'h26); bus.inst_valid = 1'b1;
    @(negedge clk); bus.inst_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    vectors++; if (bus.done !== 1'b0 || bus.Write_Reg !== 1'b0 || bus.inst_ready !== 1'b1) begin miscompares++; $display("FAIL rstex_ctrl done=%b wr=%b rdy=%b want 0/0/1", bus.done, bus.Write_Reg, bus.inst_ready); end
    vectors++; if ({bus.R_Addr_A, bus.W_Addr} !== 10'd0 || bus.W_Data !== 32'd0 || {bus.ZF, bus.OF, bus.illegal} !== 3'd0) begin miscompares++; $display("FAIL rstex_vals ra=%0d wa=%0d wd=%h zoi=%b want 0", bus.R_Addr_A, bus.W_Addr, bus.W_Data, {bus.ZF, bus.OF, bus.illegal}); end
    reset = 1'b0; any_done = 1'b0;
    repeat (4) begin @(negedge clk); if (bus.done) any_done = 1'b1; end
    vectors++; if (rf[10] !== 32'hABCD || any_done !== 1'b0) begin miscompares++; $display("FAIL rstex_nowrite r10=%h done=%b want abcd/0", rf[10], any_done); end
    preset(12, 32'h77);
    @(negedge clk); bus.inst = rinst(1, 2, 12, 0, 6'h21); bus.inst_valid = 1'b1;
    @(negedge clk); bus.inst_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; #1;
    vectors++; if (bus.Write_Reg !== 1'b0) begin miscompares++; $display("FAIL rstwb_wr got %b want 0", bus.Write_Reg); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    vectors++; if (rf[12] !== 32'h77) begin miscompares++; $display("FAIL rstwb_nowrite got %h want 00000077", rf[12]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_overflow();
    test_compare_shift();
    test_logic_arith();
    test_rd_zero();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
